modport_adder: RTL and testbench

MODPORT_ADDER -- requirements
Module: modport_adder

---
 rtl/modport_adder.sv | 85 ++++++++
 tb/tb_modport_adder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/modport_adder.sv
// Pipelined WIDTH-bit adder with carry and signed-overflow flags, 1 or 2 register stages.
// Output data holds its last result through bubbles; only out_valid tracks in_valid.
module modport_adder #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             carry,
    output logic             overflow
);

    // Reset release is retimed: nothing is accepted until one edge after rst_n rises.
    logic run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    logic accept;
    assign accept = in_valid & run;

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic             v_s;

    generate
        if (LATENCY == 2) begin : g_lat2
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic             v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    v_q <= 1'b0;
                end else begin
                    v_q <= accept;
                    if (accept) begin
                        a_q <= in1;
                        b_q <= in2;
                    end
                end
            end

            assign a_s = a_q;
            assign b_s = b_q;
            assign v_s = v_q;
        end else begin : g_lat1
            assign a_s = in1;
            assign b_s = in2;
            assign v_s = accept;
        end
    endgenerate

    logic [WIDTH:0] sum;
    logic           ovf;

    assign sum = {1'b0, a_s} + {1'b0, b_s};
    assign ovf = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum[WIDTH-1] != a_s[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= v_s;
            if (v_s) begin
                out      <= sum[WIDTH-1:0];
                carry    <= sum[WIDTH];
                overflow <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_modport_adder.sv
// Self-checking bench: LATENCY=1 and LATENCY=2 instances share stimulus and are
// compared every cycle against an arithmetic reference model with input history.
module tb_modport_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         in_valid = 1'b0;

    logic [W-1:0] out1, out2;
    logic         ov1, ov2, c1, c2, f1, f2;

    always #5 clk = ~clk;

    modport_adder #(.WIDTH(W), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .in_valid(in_valid),
        .out(out1), .out_valid(ov1), .carry(c1), .overflow(f1)
    );

    modport_adder #(.WIDTH(W), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .in_valid(in_valid),
        .out(out2), .out_valid(ov2), .carry(c2), .overflow(f2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: history of accepted operands per clock edge.
    bit           hv [0:4095];
    logic [W-1:0] ha [0:4095];
    logic [W-1:0] hb [0:4095];
    int           e   = 0;
    int           rel = 0;

    logic [W-1:0] m_out [1:2];
    bit           m_v   [1:2];
    bit           m_c   [1:2];
    bit           m_f   [1:2];

    task automatic model_clear();
        for (int i = 0; i <= e; i++) hv[i] = 1'b0;
        for (int l = 1; l <= 2; l++) begin
            m_out[l] = '0;
            m_v[l]   = 1'b0;
            m_c[l]   = 1'b0;
            m_f[l]   = 1'b0;
        end
        rel = 0;
    endtask

    task automatic model_eval(input int lat);
        int idx;
        longint unsigned u;
        longint sa, sb, ss;
        idx = e - lat + 1;
        if (idx >= 1 && hv[idx]) begin
            u  = 64'(ha[idx]) + 64'(hb[idx]);
            sa = $signed(ha[idx]);
            sb = $signed(hb[idx]);
            ss = sa + sb;
            m_out[lat] = W'(u % (64'd1 << W));
            m_c[lat]   = (u >= (64'd1 << W));
            m_f[lat]   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            m_v[lat]   = 1'b1;
        end else begin
            m_v[lat] = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_eq("l1_valid", 64'(ov1), 64'(m_v[1]));
        check_eq("l1_out",   64'(out1), 64'(m_out[1]));
        check_eq("l1_carry", 64'(c1), 64'(m_c[1]));
        check_eq("l1_ovf",   64'(f1), 64'(m_f[1]));
        check_eq("l2_valid", 64'(ov2), 64'(m_v[2]));
        check_eq("l2_out",   64'(out2), 64'(m_out[2]));
        check_eq("l2_carry", 64'(c2), 64'(m_c[2]));
        check_eq("l2_ovf",   64'(f2), 64'(m_f[2]));
    endtask

    // Drive one input set, advance one edge, then check 1 time unit later.
    task automatic cycle(input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v;
        in1      = a;
        in2      = b;
        @(posedge clk);
        e++;
        hv[e] = v && rst_n && (rel >= 1);
        ha[e] = a;
        hb[e] = b;
        if (rst_n) rel++;
        #1;
        model_eval(1);
        model_eval(2);
        compare_all();
    endtask

    task automatic reset_pulse(input int n_cycles);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        compare_all();
        for (int i = 0; i < n_cycles; i++) cycle(1'b1, $urandom, $urandom);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        #1;
        compare_all();
        cycle(1'b1, 32'd1, 32'd2);
        cycle(1'b1, 32'd1, 32'd2);
        #2;
        rst_n = 1'b1;

        // First edge after release must not accept.
        cycle(1'b1, 32'd5, 32'd7);
        check_eq("first_edge_blocked", 64'(ov1), 64'd0);
        cycle(1'b1, 32'd5, 32'd7);
        check_eq("basic_out", 64'(out1), 64'd12);
        check_eq("basic_valid", 64'(ov1), 64'd1);
        cycle(1'b0, 32'd0, 32'd0);
        check_eq("basic_hold", 64'(out1), 64'd12);
        check_eq("basic_bubble_valid", 64'(ov1), 64'd0);

        cycle(1'b1, 32'hFFFF_FFFF, 32'd1);
        check_eq("wrap_out", 64'(out1), 64'd0);
        check_eq("wrap_carry", 64'(c1), 64'd1);
        cycle(1'b1, 32'h7FFF_FFFF, 32'd1);
        check_eq("povf_out", 64'(out1), 64'h8000_0000);
        check_eq("povf_ovf", 64'(f1), 64'd1);
        cycle(1'b1, 32'h8000_0000, 32'h8000_0000);
        check_eq("novf_out", 64'(out1), 64'd0);
        check_eq("novf_carry", 64'(c1), 64'd1);
        check_eq("novf_ovf", 64'(f1), 64'd1);

        cycle(1'b1, 32'd3, 32'd4);
        for (int i = 0; i < 3; i++) cycle(1'b0, $urandom, $urandom);
        check_eq("bubble_hold_l1", 64'(out1), 64'd7);
        check_eq("bubble_hold_l2", 64'(out2), 64'd7);

        for (int i = 0; i < 100; i++) cycle(1'b1, $urandom, $urandom);
        for (int i = 0; i < 100; i++) cycle(1'($urandom_range(0, 1)), $urandom, $urandom);

        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, $urandom);
        reset_pulse(2);
        for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, $urandom);
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, $urandom);
        reset_pulse(0);
        for (int i = 0; i < 20; i++) cycle(1'($urandom_range(0, 1)), $urandom, $urandom);
        cycle(1'b0, 32'd0, 32'd0);
        cycle(1'b0, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
